core_inst_sequencer: RTL and testbench

//  Hardware replacement for bench-driven instruction sequencing of `core`.

---
 rtl/core_inst_sequencer.sv | 133 +++++++++++++
 tb/tb_core_inst_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: emits the core instruction stream for one tile over all kij passes
// Ports: clk; reset (async, active-low); start (run request, IDLE only);
//   ofifo_valid (core OFIFO has a row); inst[33:0] (registered core instruction);
//   core_rst (core array/L0/OFIFO reset); busy; done (one-cycle end pulse); kij_idx[3:0].
// Optional PERF_CNT_EN: adds stall_cnt[15:0] and cyc_cnt[15:0] performance counters.
module core_inst_sequencer #(
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16,
  parameter int W_BASE   = 1024,
  parameter int RST_CYC  = 11,
  parameter int GAP_CYC  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] cyc_cnt
`endif
);
  typedef enum logic [3:0] {IDLE, CRST, W2L0, KLOAD, GAP, A2L0, EXEC, OFRD, DONE} state_t;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam logic [7:0] RST_LAST  = 8'(RST_CYC - 1);
  localparam logic [7:0] KLD_LAST  = 8'(LEN_KIJ - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [7:0] EXE_LAST  = 8'(LEN_ONIJ - 1);
  localparam logic [7:0] RD_ALL    = 8'(LEN_ONIJ);
  localparam logic [7:0] W_LEN     = 8'(COL);
  localparam logic [7:0] A_LEN     = 8'(LEN_NIJ);
  localparam logic [3:0] KIJ_LAST  = 4'(LEN_KIJ - 1);
  state_t state, ns;
  logic [7:0] t, nt, xlen;
  logic [3:0] nk;
  logic rd, xfer, xon;
  logic [10:0] w_addr, x_addr, p_addr;
  logic [33:0] ninst;
  // Next state and step counter; in OFRD, t counts reads already issued.
  always_comb begin
    ns = state;
    nt = t + 8'd1;
    nk = kij_idx;
    rd = 1'b0;
    case (state)
      IDLE: begin
        nt = '0;
        nk = '0;
        ns = start ? CRST : IDLE;
      end
      CRST:  if (t == RST_LAST) begin ns = W2L0; nt = '0; end
      W2L0:  if (t == W_LEN) begin ns = KLOAD; nt = '0; end
      KLOAD: if (t == KLD_LAST) begin ns = GAP; nt = '0; end
      GAP:   if (t == GAP_LAST) begin ns = A2L0; nt = '0; end
      A2L0:  if (t == A_LEN) begin ns = EXEC; nt = '0; end
      EXEC:  if (t == EXE_LAST) begin
        ns = OFRD;
        rd = ofifo_valid;
        nt = {7'd0, ofifo_valid};
      end
      OFRD: begin
        if (t == RD_ALL) begin
          nt = '0;
          ns = (kij_idx == KIJ_LAST) ? DONE : CRST;
          nk = (kij_idx == KIJ_LAST) ? kij_idx : kij_idx + 4'd1;
        end else begin
          rd = ofifo_valid;
          nt = t + {7'd0, ofifo_valid};
        end
      end
      DONE: begin
        ns = IDLE;
        nt = '0;
      end
      default: begin
        ns = IDLE;
        nt = '0;
      end
    endcase
  end
  // Instruction word for the upcoming cycle, derived from the next state so inst is registered.
  assign xfer   = (ns == W2L0) || (ns == A2L0);
  assign xlen   = (ns == W2L0) ? W_LEN : A_LEN;
  assign xon    = xfer && (nt != xlen);
  assign w_addr = 11'(W_BASE + COL * int'(nk) + int'(nt));
  assign x_addr = (ns == W2L0) ? w_addr : 11'(nt);
  assign p_addr = 11'(LEN_ONIJ * int'(nk) + int'(nt) - 1);
  assign ninst  = {1'b0, !rd, !rd, rd ? p_addr : 11'd0,
                   !xon, 1'b1, xon ? x_addr : 11'd0,
                   rd, 2'b00, (ns == KLOAD) || (ns == EXEC), xfer && (nt != '0),
                   ns == EXEC, ns == KLOAD};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      t        <= '0;
      kij_idx  <= '0;
      inst     <= IDLE_INST;
      core_rst <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= ns;
      t        <= nt;
      kij_idx  <= nk;
      inst     <= ninst;
      core_rst <= ns == CRST;
      busy     <= ns != IDLE;
      done     <= state == DONE;
    end
  end
`ifdef PERF_CNT_EN
  // Stall = an OFRD cycle that carries no OFIFO read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      cyc_cnt   <= (busy && cyc_cnt != '1) ? cyc_cnt + 16'd1 : cyc_cnt;
      stall_cnt <= (state == OFRD && !inst[6] && stall_cnt != '1) ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb_core_inst_sequencer: randomized self-checking bench for core_inst_sequencer
// Ports: none (drives clk, reset, start, ofifo_valid; observes all DUT outputs).
// Honours PERF_CNT_EN when the DUT is built with it.
module tb_core_inst_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic core_rst, busy, done;
  logic [3:0] kij_idx;
`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt, cyc_cnt;
`endif
  int checks = 0, errors = 0;
  int wr_cnt[144];
  int wr_total;
  logic [34:0] exp_q[$];
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  core_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .core_rst(core_rst), .busy(busy), .done(done), .kij_idx(kij_idx)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .cyc_cnt(cyc_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [34:0] mk(input bit cr, input bit xon, input int xa,
                                     input bit l0wr, input bit ld, input bit l0rd, input bit ex);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = !xon;
    w[17:7] = xon ? 11'(xa) : 11'd0;
    w[3] = l0rd;
    w[2] = l0wr;
    w[1] = ex;
    w[0] = ld;
    return {cr, w};
  endfunction
  // Expected {core_rst, inst} for every cycle of kij k before the OFIFO drain.
  task automatic build(input int k);
    for (int i = 0; i < 11; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= 8; i++) exp_q.push_back(mk(0, i < 8, 1024 + k * 8 + i, i > 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 11; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= 36; i++) exp_q.push_back(mk(0, i < 36, i, i > 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
  endtask
  // mode 0: valid always 1; 1: random valid; 2: extra start in A2L0 of kij 4;
  // 3: five-cycle valid drop after 8 reads of kij 2. abort: reset mid-EXEC of kij 1.
  task automatic run_tile(input int mode, input bit abort);
    int k = 0, rd_n = 0, cyc = 0, nstall = 0, sl = 0;
    bit pv = 1'b1, fin = 1'b0, in_done = 1'b0, stalled = 1'b0;
    logic [33:0] rw;
    exp_q.delete();
    build(0);
    for (int i = 0; i < 144; i++) wr_cnt[i] = 0;
    wr_total = 0;
    start = 1'b1;
    ofifo_valid = 1'b1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (exp_q.size() != 0) begin
        chk("seq", {core_rst, inst}, exp_q.pop_front());
        chk("busy", busy, 1);
        chk("done_low", done, 0);
        chk("kij", kij_idx, k);
        if (abort && k == 1 && exp_q.size() == 8) begin
          reset = 1'b0;
          #1;
          chk("rst_inst", inst, IDLE_W);
          chk("rst_busy", busy, 0);
          chk("rst_core_rst", core_rst, 0);
          chk("rst_kij", kij_idx, 0);
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        if (mode == 2 && k == 4 && exp_q.size() == 30) start = 1'b1;
      end else if (rd_n < 16) begin
        chk("busy", busy, 1);
        chk("kij", kij_idx, k);
        if (pv) begin
          rw = IDLE_W;
          rw[32] = 1'b0;
          rw[31] = 1'b0;
          rw[30:20] = 11'(k * 16 + rd_n);
          rw[6] = 1'b1;
          chk("pmem_wr", {core_rst, inst}, {1'b0, rw});
          wr_cnt[k * 16 + rd_n]++;
          wr_total++;
          rd_n++;
          if (rd_n == 16 && k < 8) begin
            k++;
            rd_n = 0;
            build(k);
          end
        end else begin
          chk("stall", {core_rst, inst}, {1'b0, IDLE_W});
          nstall++;
        end
      end else if (!in_done) begin
        chk("done_state_inst", {core_rst, inst}, {1'b0, IDLE_W});
        chk("done_state_busy", busy, 1);
        chk("done_state_done", done, 0);
        in_done = 1'b1;
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_lat", cyc - 1, 982 + nstall);
`ifdef PERF_CNT_EN
        chk("cyc_cnt", cyc_cnt, 982 + nstall);
        chk("stall_cnt", stall_cnt, nstall);
`endif
        fin = 1'b1;
      end
      if (mode == 1) ofifo_valid = $urandom_range(0, 3) != 0;
      else if (mode == 3) begin
        if (k == 2 && rd_n == 8 && !stalled) begin
          sl = 5;
          stalled = 1'b1;
        end
        ofifo_valid = sl == 0;
        if (sl > 0) sl--;
      end
      pv = ofifo_valid;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("pmem_total", wr_total, 144);
    begin
      int bad = 0;
      for (int i = 0; i < 144; i++) if (wr_cnt[i] != 1) bad++;
      chk("pmem_once", bad, 0);
    end
    repeat (3) @(negedge clk);
    chk("idle_inst", inst, IDLE_W);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
`ifdef PERF_CNT_EN
    chk("cyc_hold", cyc_cnt, 982 + nstall);
    chk("stall_hold", stall_cnt, nstall);
`endif
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_inst", inst, IDLE_W);
    chk("reset_busy", busy, 0);
    chk("reset_core_rst", core_rst, 0);
    chk("reset_done", done, 0);
    chk("reset_kij", kij_idx, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", inst, IDLE_W);
    run_tile(0, 1'b0);
    run_tile(0, 1'b1);
    run_tile(0, 1'b0);
    run_tile(3, 1'b0);
    run_tile(2, 1'b0);
    run_tile(1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
